// File: rtl/dual_port_bram_pkg.sv
// Shared widths and word/address types for the 16x8 true dual-port block RAM.
// One port request bundles a write and a read; the helper builds the bundle for callers.
package dual_port_bram_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

    typedef struct packed {
        logic  wr_vld;
        addr_t wr_addr;
        data_t wr_dat;
        logic  rd_vld;
        addr_t rd_addr;
    } port_req_t;

    function automatic port_req_t make_req(input logic  wr_vld,
                                           input addr_t wr_addr,
                                           input data_t wr_dat,
                                           input logic  rd_vld,
                                           input addr_t rd_addr);
        port_req_t req;
        req.wr_vld  = wr_vld;
        req.wr_addr = wr_addr;
        req.wr_dat  = wr_dat;
        req.rd_vld  = rd_vld;
        req.rd_addr = rd_addr;
        return req;
    endfunction

endpackage

// File: rtl/bram_read_port.sv
// Enable-gated registered read output with synchronous active-high clear.
// Latency 1 cycle; no backpressure, the output simply holds while the enable is low.
module bram_read_port
    import dual_port_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_en_i,
    input  logic [DATA_WIDTH-1:0] rd_dat_i,
    output logic [DATA_WIDTH-1:0] rd_dat_o
);

    logic [DATA_WIDTH-1:0] rd_dat_q;
    logic [DATA_WIDTH-1:0] rd_dat_d;

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en_i) begin
            rd_dat_d = rd_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/dual_port_bram_16x8.sv
// True dual-port 16x8 RAM, one clock, read-first, port A wins write collisions.
// Read latency 1 cycle, write visible to reads enabled on the next edge; no backpressure.
module dual_port_bram_16x8
    import dual_port_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,

    input  logic                  i_WRITE_ENABLE_A,
    input  logic [ADDR_WIDTH-1:0] i_WRITE_ADDRESS_A,
    input  logic [DATA_WIDTH-1:0] i_WRITE_DATA_A,
    input  logic                  i_READ_ENABLE_A,
    input  logic [ADDR_WIDTH-1:0] i_READ_ADDRESS_A,
    output logic [DATA_WIDTH-1:0] o_READ_DATA_A,

    input  logic                  i_WRITE_ENABLE_B,
    input  logic [ADDR_WIDTH-1:0] i_WRITE_ADDRESS_B,
    input  logic [DATA_WIDTH-1:0] i_WRITE_DATA_B,
    input  logic                  i_READ_ENABLE_B,
    input  logic [ADDR_WIDTH-1:0] i_READ_ADDRESS_B,
    output logic [DATA_WIDTH-1:0] o_READ_DATA_B
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_mem_a;
    logic [DATA_WIDTH-1:0] rd_mem_b;
    logic                  wr_en_a;
    logic                  wr_en_b;
    logic                  rd_en_a;
    logic                  rd_en_b;

    assign wr_en_a = i_WRITE_ENABLE_A && !i_RST;
    assign wr_en_b = i_WRITE_ENABLE_B && !i_RST;
    assign rd_en_a = i_READ_ENABLE_A;
    assign rd_en_b = i_READ_ENABLE_B;

    // Port B is applied first so port A's assignment lands last on a shared address.
    always_ff @(posedge i_CLK) begin
        if (wr_en_b) begin
            mem_q[i_WRITE_ADDRESS_B] <= i_WRITE_DATA_B;
        end
        if (wr_en_a) begin
            mem_q[i_WRITE_ADDRESS_A] <= i_WRITE_DATA_A;
        end
    end

    // Array is sampled before this edge's writes settle, giving read-first behaviour.
    assign rd_mem_a = mem_q[i_READ_ADDRESS_A];
    assign rd_mem_b = mem_q[i_READ_ADDRESS_B];

    bram_read_port #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_port_a (
        .clk_i    (i_CLK),
        .rst_i    (i_RST),
        .rd_en_i  (rd_en_a),
        .rd_dat_i (rd_mem_a),
        .rd_dat_o (o_READ_DATA_A)
    );

    bram_read_port #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_port_b (
        .clk_i    (i_CLK),
        .rst_i    (i_RST),
        .rd_en_i  (rd_en_b),
        .rd_dat_i (rd_mem_b),
        .rd_dat_o (o_READ_DATA_B)
    );

`ifdef FORMAL
    logic past_valid_q = 1'b0;

    always_ff @(posedge i_CLK) begin
        past_valid_q <= 1'b1;
    end

    always @(posedge i_CLK) begin
        if (past_valid_q && !$past(i_RST)) begin
            if ($past(i_READ_ENABLE_A)) begin
                assert (o_READ_DATA_A == $past(mem_q[i_READ_ADDRESS_A]));
            end
            if ($past(i_READ_ENABLE_B)) begin
                assert (o_READ_DATA_B == $past(mem_q[i_READ_ADDRESS_B]));
            end
            if ($past(i_WRITE_ENABLE_A)) begin
                assert (mem_q[$past(i_WRITE_ADDRESS_A)] == $past(i_WRITE_DATA_A));
            end
            if ($past(i_WRITE_ENABLE_B) &&
                !($past(i_WRITE_ENABLE_A) && $past(i_WRITE_ADDRESS_A) == $past(i_WRITE_ADDRESS_B))) begin
                assert (mem_q[$past(i_WRITE_ADDRESS_B)] == $past(i_WRITE_DATA_B));
            end
        end
    end
`endif

endmodule

// File: tb/tb_dual_port_bram_16x8.sv
// Directed and random checks of the 16x8 dual-port RAM against an array model.
module tb_dual_port_bram_16x8;
    import dual_port_bram_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       we_a, re_a, we_b, re_b;
    logic [3:0] wa_a, ra_a, wa_b, ra_b;
    logic [7:0] wd_a, wd_b;
    logic [7:0] rd_a, rd_b;

    logic [7:0] exp_mem [16];
    logic [7:0] exp_a, exp_b;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    dual_port_bram_16x8 dut (
        .i_CLK             (clk),
        .i_RST             (rst),
        .i_WRITE_ENABLE_A  (we_a),
        .i_WRITE_ADDRESS_A (wa_a),
        .i_WRITE_DATA_A    (wd_a),
        .i_READ_ENABLE_A   (re_a),
        .i_READ_ADDRESS_A  (ra_a),
        .o_READ_DATA_A     (rd_a),
        .i_WRITE_ENABLE_B  (we_b),
        .i_WRITE_ADDRESS_B (wa_b),
        .i_WRITE_DATA_B    (wd_b),
        .i_READ_ENABLE_B   (re_b),
        .i_READ_ADDRESS_B  (ra_b),
        .o_READ_DATA_B     (rd_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        rst  = 1'b0;
        we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
    endtask

    // One clock edge: the model applies the behavioural rules, then both outputs are compared.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_a = 8'h00;
            exp_b = 8'h00;
        end else begin
            if (re_a) exp_a = exp_mem[ra_a];
            if (re_b) exp_b = exp_mem[ra_b];
            if (we_b) exp_mem[wa_b] = wd_b;
            if (we_a) exp_mem[wa_a] = wd_a;
        end
        #1;
        chk("model_a", rd_a, exp_a);
        chk("model_b", rd_b, exp_b);
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [7:0] d);
        idle(); we_a = 1'b1; wa_a = a; wd_a = d; tick();
    endtask

    initial begin
        port_req_t req;
        idle();
        wa_a = '0; ra_a = '0; wa_b = '0; ra_b = '0; wd_a = '0; wd_b = '0;
        exp_a = 8'h00; exp_b = 8'h00;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'hxx;

        rst = 1'b1;
        @(posedge clk); #1;
        tick();
        chk("reset_a", rd_a, 8'h00);
        chk("reset_b", rd_b, 8'h00);

        // Sweep: address*3 written through alternating ports, read back on both.
        for (int i = 0; i < 16; i++) begin
            idle();
            if (i % 2 == 0) begin we_a = 1'b1; wa_a = 4'(i); wd_a = 8'(i * 3); end
            else            begin we_b = 1'b1; wa_b = 4'(i); wd_b = 8'(i * 3); end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            re_a = 1'b1; ra_a = 4'(i);
            re_b = 1'b1; ra_b = 4'(15 - i);
            tick();
            chk("sweep_a", rd_a, 8'(i * 3));
            chk("sweep_b", rd_b, 8'((15 - i) * 3));
        end

        // Reset with reads enabled and a write attempt: outputs clear, memory untouched.
        wr_a(4'd15, 8'h87);
        idle(); rst = 1'b1;
        re_a = 1'b1; ra_a = 4'd15; re_b = 1'b1; ra_b = 4'd15;
        we_b = 1'b1; wa_b = 4'd15; wd_b = 8'hFF;
        exp_mem[15] = 8'h87;
        tick();
        chk("rst_hold_a", rd_a, 8'h00);
        chk("rst_hold_b", rd_b, 8'h00);
        idle(); re_b = 1'b1; ra_b = 4'd15;
        tick();
        chk("post_rst_b", rd_b, 8'h87);
        chk("post_rst_a", rd_a, 8'h00);

        // Read-first on a cross-port write to the same address.
        wr_a(4'd13, 8'h56);
        idle(); we_a = 1'b1; wa_a = 4'd13; wd_a = 8'h46; re_b = 1'b1; ra_b = 4'd13;
        tick();
        chk("rdfirst_old", rd_b, 8'h56);
        idle(); re_b = 1'b1; ra_b = 4'd13;
        tick();
        chk("rdfirst_new", rd_b, 8'h46);

        // Same-port read during write.
        idle(); we_a = 1'b1; wa_a = 4'd9; wd_a = 8'hC3; re_a = 1'b1; ra_a = 4'd9;
        tick();
        chk("same_port_old", rd_a, 8'(9 * 3));

        // Hold while enable is low and the address moves.
        wr_a(4'd7, 8'h15);
        idle(); re_a = 1'b1; ra_a = 4'd7;
        tick();
        chk("hold_load", rd_a, 8'h15);
        for (int i = 0; i < 3; i++) begin
            idle(); ra_a = 4'd8;
            tick();
            chk("hold", rd_a, 8'h15);
        end

        // Write collision: port A wins.
        idle(); we_a = 1'b1; wa_a = 4'd0; wd_a = 8'hAA; we_b = 1'b1; wa_b = 4'd0; wd_b = 8'h55;
        tick();
        idle(); re_a = 1'b1; ra_a = 4'd0; re_b = 1'b1; ra_b = 4'd0;
        tick();
        chk("collide_a", rd_a, 8'hAA);
        chk("collide_b", rd_b, 8'hAA);

        // Parallel writes then crossed reads.
        idle(); we_a = 1'b1; wa_a = 4'd2; wd_a = 8'h11; we_b = 1'b1; wa_b = 4'd3; wd_b = 8'h22;
        tick();
        idle(); re_a = 1'b1; ra_a = 4'd3; re_b = 1'b1; ra_b = 4'd2;
        tick();
        chk("par_a", rd_a, 8'h22);
        chk("par_b", rd_b, 8'h11);

        // Mid-operation reset keeps memory contents.
        idle(); rst = 1'b1;
        tick();
        chk("mid_rst_a", rd_a, 8'h00);
        idle(); re_a = 1'b1; ra_a = 4'd2; re_b = 1'b1; ra_b = 4'd3;
        tick();
        chk("kept_a", rd_a, 8'h11);
        chk("kept_b", rd_b, 8'h22);

        // Random traffic on all four accesses with occasional reset.
        for (int n = 0; n < 400; n++) begin
            req  = make_req(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            we_a = req.wr_vld; wa_a = req.wr_addr; wd_a = req.wr_dat;
            re_a = req.rd_vld; ra_a = req.rd_addr;
            req  = make_req(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
            we_b = req.wr_vld; wa_b = req.wr_addr; wd_b = req.wr_dat;
            re_b = req.rd_vld; ra_b = req.rd_addr;
            if (n % 8 == 3) begin wa_b = wa_a; ra_b = wa_a; end
            rst  = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
